// File: rtl/mem_responder_pkg.sv
// Shared constants, types and helpers for the memory-side bus responder.
package mem_responder_pkg;

  // Bus command encodings; 2'b11 is unused and decodes like BUS_NONE.
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int MEM_LATENCY_DEFAULT = 6;

  // Tags are 4 bits wide; 0 means "no tag", so issue order is 1..15, 1, ...
  localparam int         TAG_W     = 4;
  localparam logic [3:0] TAG_FIRST = 4'd1;
  localparam logic [3:0] TAG_LAST  = 4'd15;

  // One slot of the load-return pipeline.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } ret_entry_t;

  // Next tag in issue order, skipping 0.
  function automatic logic [3:0] tag_advance(input logic [3:0] tag);
    if (tag == TAG_LAST) begin
      return TAG_FIRST;
    end else begin
      return tag + 4'd1;
    end
  endfunction

endpackage

// File: rtl/mem_responder_return_pipe.sv
// Fixed-latency return pipeline for accepted loads. The last stage is the
// registered output; its valid bit marks a load retiring this cycle.
module mem_return_pipe
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_push,
  input  logic [3:0]  i_tag,
  input  logic [63:0] i_data,
  output logic [3:0]  o_tag,
  output logic [63:0] o_data,
  output logic        o_retiring,
  output logic [3:0]  o_inflight
);

  ret_entry_t r_stage [LATENCY];
  ret_entry_t w_in;
  logic [3:0] w_count;

  // Build the entry for stage 0; empty slots carry zero tag and data so the
  // last stage can drive the outputs directly.
  always_comb begin
    w_in = '0;
    if (i_push) begin
      w_in.valid = 1'b1;
      w_in.tag   = i_tag;
      w_in.data  = i_data;
    end else begin
      w_in = '0;
    end
  end

  // Shift entries one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= w_in;
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // Loads in flight = number of occupied stages, including the retiring one.
  always_comb begin
    w_count = 4'd0;
    for (int i = 0; i < LATENCY; i++) begin
      w_count = w_count + {3'b000, r_stage[i].valid};
    end
  end

  assign o_tag      = r_stage[LATENCY-1].tag;
  assign o_data     = r_stage[LATENCY-1].data;
  assign o_retiring = r_stage[LATENCY-1].valid;
  assign o_inflight = w_count;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts loads/stores, tags each accepted command,
// and returns load data in order a fixed number of cycles after acceptance.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY     = MEM_LATENCY_DEFAULT,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DEPTH_WORDS     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [63:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [63:0]      r_mem [DEPTH_WORDS];
  logic [3:0]       r_next_tag;

  logic [IDX_W-1:0] w_idx;
  logic [63-IDX_W:0] w_unused_addr;
  logic [63:0]      w_rd_data;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_retiring;
  logic [3:0]       w_inflight;
  logic [3:0]       w_inflight_net;
  logic             w_room;
  logic             w_accept_load;
  logic             w_accept_store;
  logic             w_accept;

  // Word index; byte offset and bits above the array size alias away.
  assign w_idx         = proc2mem_addr[3 +: IDX_W];
  assign w_unused_addr = {proc2mem_addr[63:3+IDX_W], proc2mem_addr[2:0]};

  // Decode the bus command; the unused encoding behaves as BUS_NONE.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    case (proc2mem_command)
      BUS_LOAD:  w_is_load  = 1'b1;
      BUS_STORE: w_is_store = 1'b1;
      default: begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
      end
    endcase
  end

  // A load retiring this cycle frees its slot for this cycle's request.
  assign w_inflight_net = w_inflight - {3'b000, w_retiring};
  assign w_room         = (w_inflight_net < MAX_OUT);

  assign w_accept_load  = !reset && w_is_load && w_room;
  assign w_accept_store = !reset && w_is_store;
  assign w_accept       = w_accept_load || w_accept_store;

  assign mem2proc_response = w_accept ? r_next_tag : 4'd0;

  // Asynchronous read so a load captures the array as of its accept cycle.
  assign w_rd_data = r_mem[w_idx];

  // Backing store write; contents intentionally survive reset.
  always_ff @(posedge clock) begin
    if (w_accept_store) begin
      r_mem[w_idx] <= proc2mem_data;
    end
  end

  // Tag allocator: advances on every accepted command, never issues 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_next_tag <= TAG_FIRST;
    end else if (w_accept) begin
      r_next_tag <= tag_advance(r_next_tag);
    end else begin
      r_next_tag <= r_next_tag;
    end
  end

  mem_return_pipe #(
    .LATENCY (MEM_LATENCY)
  ) u_return_pipe (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_accept_load),
    .i_tag      (r_next_tag),
    .i_data     (w_rd_data),
    .o_tag      (mem2proc_tag),
    .o_data     (mem2proc_data),
    .o_retiring (w_retiring),
    .o_inflight (w_inflight)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a random
// command mix, all compared against a transaction-level reference model.
module tb_mem_responder;

  localparam int LAT   = 6;
  localparam int MAXO  = 4;
  localparam int DEPTH = 1024;
  localparam int IDX_W = 10;

  localparam logic [1:0] C_NONE  = 2'h0;
  localparam logic [1:0] C_LOAD  = 2'h1;
  localparam logic [1:0] C_STORE = 2'h2;
  localparam logic [1:0] C_RSVD  = 2'h3;

  logic        clock;
  logic        reset;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  mem_responder #(
    .MEM_LATENCY     (LAT),
    .MAX_OUTSTANDING (MAXO),
    .DEPTH_WORDS     (DEPTH)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: word array, pending-return queue, next tag.
  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;

  ret_t        exp_q[$];
  logic [63:0] mdl_mem [int];
  bit          written [DEPTH];
  int          mdl_tag;
  int          cyc;
  int          n_pass;
  int          n_total;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s (cycle %0d): observed 0x%0h expected 0x%0h", name, cyc, obs, exp);
  endtask

  // One bus cycle: drive, check at the falling edge, advance the model.
  task automatic do_cycle(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data,
                          output logic [3:0] o_resp, output logic [3:0] o_tag, output logic [63:0] o_data);
    int          idx;
    bit          retiring;
    bit          acc;
    logic [3:0]  e_tag;
    logic [63:0] e_data;
    proc2mem_command = cmd;
    proc2mem_addr    = addr;
    proc2mem_data    = data;
    @(negedge clock);
    idx      = int'(addr[3 +: IDX_W]);
    retiring = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    e_tag    = retiring ? exp_q[0].tag  : 4'd0;
    e_data   = retiring ? exp_q[0].data : 64'd0;
    acc      = (cmd == C_STORE) || ((cmd == C_LOAD) && ((exp_q.size() - int'(retiring)) < MAXO));
    o_resp   = mem2proc_response;
    o_tag    = mem2proc_tag;
    o_data   = mem2proc_data;
    chk("response", {60'd0, o_resp}, acc ? 64'(mdl_tag) : 64'd0);
    chk("ret_tag",  {60'd0, o_tag},  {60'd0, e_tag});
    chk("ret_data", o_data, e_data);
    if (retiring) void'(exp_q.pop_front());
    if (acc) begin
      if (cmd == C_STORE) begin
        mdl_mem[idx] = data;
        written[idx] = 1'b1;
      end else begin
        exp_q.push_back('{cyc + LAT, 4'(mdl_tag), mdl_mem[idx]});
      end
      mdl_tag = (mdl_tag == 15) ? 1 : mdl_tag + 1;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // One cycle with reset high; a load is presented to confirm it is refused.
  task automatic reset_cycle();
    reset            = 1'b1;
    proc2mem_command = C_LOAD;
    proc2mem_addr    = 64'h40;
    @(negedge clock);
    chk("reset_response", {60'd0, mem2proc_response}, 64'd0);
    exp_q.delete();
    mdl_tag = 1;
    @(posedge clock);
    #1;
    reset            = 1'b0;
    proc2mem_command = C_NONE;
    cyc++;
  endtask

  initial begin
    logic [3:0]  r_resp;
    logic [3:0]  r_tag;
    logic [63:0] r_data;
    logic [63:0] a;
    int          idx;
    logic [1:0]  cmd;
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    mdl_tag = 1;
    reset            = 1'b1;
    proc2mem_command = C_NONE;
    proc2mem_addr    = 64'd0;
    proc2mem_data    = 64'd0;
    @(posedge clock);
    #1;
    reset_cycle();
    reset_cycle();

    // Outputs idle right after reset.
    do_cycle(C_NONE, 64'd0, 64'd0, r_resp, r_tag, r_data);
    chk("post_reset_tag", {60'd0, r_tag}, 64'd0);

    // Store then load of the same word; data returns LAT cycles later.
    do_cycle(C_STORE, 64'h40, 64'hDEADBEEF_CAFEF00D, r_resp, r_tag, r_data);
    chk("store_resp_1", {60'd0, r_resp}, 64'd1);
    do_cycle(C_LOAD, 64'h40, 64'd0, r_resp, r_tag, r_data);
    chk("load_resp_2", {60'd0, r_resp}, 64'd2);
    for (int i = 1; i <= LAT; i++) do_cycle(C_NONE, 64'd0, 64'd0, r_resp, r_tag, r_data);
    chk("load_ret_tag", {60'd0, r_tag}, 64'd2);
    chk("load_ret_data", r_data, 64'hDEADBEEF_CAFEF00D);

    // Address beyond the array aliases onto the same word.
    do_cycle(C_LOAD, 64'h40 + 64'(DEPTH * 8), 64'd0, r_resp, r_tag, r_data);
    chk("alias_resp", {60'd0, r_resp}, 64'd3);
    for (int i = 1; i <= LAT; i++) do_cycle(C_NONE, 64'd0, 64'd0, r_resp, r_tag, r_data);
    chk("alias_ret_data", r_data, 64'hDEADBEEF_CAFEF00D);

    // Back-to-back loads saturate the outstanding limit; the fifth is retried.
    reset_cycle();
    for (int k = 0; k < 7; k++) begin
      do_cycle(C_LOAD, 64'h40, 64'd0, r_resp, r_tag, r_data);
      chk("b2b_resp", {60'd0, r_resp}, (k < 4) ? 64'(k + 1) : ((k == 6) ? 64'd5 : 64'd0));
    end
    chk("b2b_retire_tag", {60'd0, r_tag}, 64'd1);
    for (int i = 0; i < LAT + 2; i++) do_cycle(C_NONE, 64'd0, 64'd0, r_resp, r_tag, r_data);

    // Sixteen stores wrap the tag 15 -> 1 and never produce a return.
    reset_cycle();
    for (int i = 0; i < 16; i++) begin
      do_cycle(C_STORE, 64'(i * 8), {$urandom(), $urandom()}, r_resp, r_tag, r_data);
      chk("store_wrap_resp", {60'd0, r_resp}, (i < 15) ? 64'(i + 1) : 64'd1);
    end

    // Idle encodings are refused and do not consume a tag.
    do_cycle(C_RSVD, 64'h8, 64'h1234, r_resp, r_tag, r_data);
    do_cycle(C_NONE, 64'h8, 64'h1234, r_resp, r_tag, r_data);
    do_cycle(C_STORE, 64'h88, 64'h5555_AAAA_0000_FFFF, r_resp, r_tag, r_data);
    chk("tag_kept_over_idle", {60'd0, r_resp}, 64'd2);

    // Reset with loads in flight drops them and restarts tags at 1.
    for (int i = 0; i < 3; i++) do_cycle(C_LOAD, 64'(i * 8), 64'd0, r_resp, r_tag, r_data);
    reset_cycle();
    for (int i = 0; i < LAT + 2; i++) do_cycle(C_NONE, 64'd0, 64'd0, r_resp, r_tag, r_data);
    do_cycle(C_STORE, 64'h10, 64'h0123_4567_89AB_CDEF, r_resp, r_tag, r_data);
    chk("first_after_reset", {60'd0, r_resp}, 64'd1);

    // Random command mix over written words with random alias bits.
    for (int n = 0; n < 400; n++) begin
      cmd = 2'($urandom_range(0, 3));
      if (cmd == C_LOAD) cmd = ($urandom_range(0, 2) != 0) ? C_LOAD : C_LOAD;
      idx = $urandom_range(0, 31);
      if ((cmd == C_LOAD) && !written[idx]) idx = $urandom_range(0, 15);
      a = {$urandom(), $urandom()};
      a[3 +: IDX_W] = IDX_W'(idx);
      do_cycle(cmd, a, {$urandom(), $urandom()}, r_resp, r_tag, r_data);
    end
    for (int i = 0; i < LAT + 2; i++) do_cycle(C_NONE, 64'd0, 64'd0, r_resp, r_tag, r_data);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
